// File: rtl/byte_stream_arbiter.sv
// Round-robin arbiter sharing one byte sink among NUM_SRC byte sources.
// Grants are held for a whole packet (EOP byte or MAX_BURST bytes); the output stage is a single register.
module byte_stream_arbiter #(
    parameter int          NUM_SRC    = 4,
    parameter int          MAX_BURST  = 8,
    parameter bit          EOP_ENABLE = 1'b1,
    parameter logic [7:0]  EOP_BYTE   = 8'h0A,
    localparam int         SW         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                 _clock,
    input  logic                 _reset,
    input  logic [NUM_SRC*8-1:0] _in,
    input  logic [NUM_SRC-1:0]   _in_valid,
    output logic [NUM_SRC-1:0]   _in_ready,
    output logic [7:0]           _out,
    output logic                 _out_valid,
    input  logic                 _out_ready,
    output logic [SW-1:0]        _out_src,
    output logic                 _busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, next_state;
    logic [SW-1:0] grant, last_grant, pick, scan_idx;
    logic          any_valid;
    logic [7:0]    burst_cnt, burst_next, g_byte;
    logic          rdy_g, in_xfer, release_c;

    // Scan downward so the nearest valid source after last_grant is the one left in pick.
    always_comb begin
        pick      = last_grant;
        any_valid = 1'b0;
        scan_idx  = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            scan_idx = SW'((int'(last_grant) + k) % NUM_SRC);
            if (_in_valid[scan_idx]) begin
                pick      = scan_idx;
                any_valid = 1'b1;
            end
        end
    end

    assign g_byte     = _in[8*int'(grant) +: 8];
    assign rdy_g      = !_out_valid || _out_ready;
    assign in_xfer    = (state == GRANT) && _in_valid[grant] && rdy_g;
    assign burst_next = (burst_cnt == 8'hFF) ? burst_cnt : burst_cnt + 8'd1;
    assign release_c  = (in_xfer && burst_next == 8'(MAX_BURST))
                     || (EOP_ENABLE && in_xfer && g_byte == EOP_BYTE)
                     || (!EOP_ENABLE && !_in_valid[grant]);

    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= SW'(NUM_SRC - 1);
            burst_cnt  <= '0;
            _out       <= '0;
            _out_valid <= 1'b0;
            _out_src   <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && any_valid) begin
                grant      <= pick;
                last_grant <= pick;
                burst_cnt  <= '0;
            end
            if (in_xfer) begin
                _out       <= g_byte;
                _out_src   <= grant;
                _out_valid <= 1'b1;
                burst_cnt  <= burst_next;
            end else if (_out_valid && _out_ready) begin
                _out_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_valid) next_state = GRANT;
            GRANT:   if (release_c) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Ready to the granted source is combinational on _out_ready for back-to-back bytes.
    always_comb begin
        _in_ready = '0;
        if (state == GRANT && rdy_g) _in_ready[grant] = 1'b1;
    end

    assign _busy = (state == GRANT) || _out_valid;

endmodule

// File: tb/tb_byte_stream_arbiter.sv
// Randomized bench: two arbiters (EOP-locked burst 8, bubble-release burst 3) vs a cycle-level reference model.
module tb_byte_stream_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [N*8-1:0]    in_bus [2];
    logic [N-1:0]      in_vld [2];
    logic [N-1:0]      in_rdy [2];
    logic [7:0]        out_b  [2];
    logic              out_v  [2];
    logic              out_r  [2];
    logic [1:0]        out_s  [2];
    logic              busy   [2];

    byte_stream_arbiter #(.NUM_SRC(N), .MAX_BURST(8), .EOP_ENABLE(1'b1), .EOP_BYTE(8'h0A)) u_eop (
        ._clock(clk), ._reset(rst_n), ._in(in_bus[0]), ._in_valid(in_vld[0]), ._in_ready(in_rdy[0]),
        ._out(out_b[0]), ._out_valid(out_v[0]), ._out_ready(out_r[0]), ._out_src(out_s[0]), ._busy(busy[0]));

    byte_stream_arbiter #(.NUM_SRC(N), .MAX_BURST(3), .EOP_ENABLE(1'b0), .EOP_BYTE(8'h0A)) u_bub (
        ._clock(clk), ._reset(rst_n), ._in(in_bus[1]), ._in_valid(in_vld[1]), ._in_ready(in_rdy[1]),
        ._out(out_b[1]), ._out_valid(out_v[1]), ._out_ready(out_r[1]), ._out_src(out_s[1]), ._busy(busy[1]));

    int         mb [2] = '{8, 3};
    bit         ee [2] = '{1'b1, 1'b0};

    // reference model: -1 grant means no source owns the sink
    int         m_grant [2], m_last [2], m_cnt [2], m_osrc [2];
    logic [7:0] m_ob [2];
    bit         m_ov [2];

    logic [7:0] cur [2][N];
    bit [N-1:0] sv  [2];

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] new_byte();
        return ($urandom_range(0, 4) == 0) ? 8'h0A : 8'($urandom);
    endfunction

    function automatic logic [N-1:0] exp_rdy(input int d);
        logic [N-1:0] r = '0;
        if (m_grant[d] >= 0 && (!m_ov[d] || out_r[d])) r[m_grant[d]] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_grant[d] = -1; m_last[d] = N - 1; m_cnt[d] = 0;
            m_ob[d] = 8'h00; m_ov[d] = 1'b0; m_osrc[d] = 0;
        end
    endtask

    task automatic check_outputs(input int d);
        chk($sformatf("d%0d_in_ready", d), 32'(in_rdy[d]), 32'(exp_rdy(d)));
        chk($sformatf("d%0d_out_valid", d), 32'(out_v[d]), 32'(m_ov[d]));
        chk($sformatf("d%0d_busy", d), 32'(busy[d]), 32'(m_grant[d] >= 0 || m_ov[d]));
        if (m_ov[d]) begin
            chk($sformatf("d%0d_out", d), 32'(out_b[d]), 32'(m_ob[d]));
            chk($sformatf("d%0d_out_src", d), 32'(out_s[d]), 32'(m_osrc[d]));
        end
    endtask

    // One clock edge of the model: arbitration, byte acceptance, release rules, sink drain.
    task automatic model_step(input int d, input logic [N-1:0] r);
        bit xfer = 1'b0;
        bit oxfer = m_ov[d] && out_r[d];
        int g = m_grant[d];
        if (g < 0) begin
            for (int k = 1; k <= N; k++) begin
                if (in_vld[d][(m_last[d] + k) % N]) begin
                    m_grant[d] = (m_last[d] + k) % N;
                    m_last[d]  = m_grant[d];
                    m_cnt[d]   = 0;
                    break;
                end
            end
        end else begin
            xfer = sv[d][g] && r[g];
            if (xfer) begin
                m_ob[d] = cur[d][g]; m_osrc[d] = g; m_ov[d] = 1'b1;
                if (m_cnt[d] < 255) m_cnt[d]++;
                if (m_cnt[d] == mb[d] || (ee[d] && cur[d][g] == 8'h0A)) m_grant[d] = -1;
            end else if (!ee[d] && !sv[d][g]) begin
                m_grant[d] = -1;
            end
        end
        if (!xfer && oxfer) m_ov[d] = 1'b0;
    endtask

    initial begin
        int pv, pr;
        logic [N-1:0] r [2];
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            sv[d] = '0; out_r[d] = 1'b0;
            for (int i = 0; i < N; i++) cur[d][i] = new_byte();
            in_vld[d] = '0; in_bus[d] = '0;
        end
        model_reset();
        #12;
        for (int d = 0; d < 2; d++) begin
            check_outputs(d);
            chk($sformatf("d%0d_rst_out", d), 32'(out_b[d]), 32'h0);
            chk($sformatf("d%0d_rst_src", d), 32'(out_s[d]), 32'h0);
        end

        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            rst_n = 1'b1;
            pv = (cyc < 300) ? 100 : (cyc < 800) ? 60 : 30;
            pr = (cyc < 300) ? 100 : (cyc < 800) ? 70 : 40;
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < N; i++) begin
                    if (!sv[d][i]) sv[d][i] = ($urandom_range(0, 99) < pv);
                    in_bus[d][8*i +: 8] = cur[d][i];
                end
                in_vld[d] = sv[d];
                out_r[d]  = ($urandom_range(0, 99) < pr);
            end
            #1;
            for (int d = 0; d < 2; d++) check_outputs(d);

            if (cyc == 500 || cyc == 1100) begin
                #1 rst_n = 1'b0;
                #1;
                for (int d = 0; d < 2; d++) begin
                    chk($sformatf("d%0d_async_rst_valid", d), 32'(out_v[d]), 32'h0);
                    chk($sformatf("d%0d_async_rst_ready", d), 32'(in_rdy[d]), 32'h0);
                    chk($sformatf("d%0d_async_rst_busy", d), 32'(busy[d]), 32'h0);
                end
                model_reset();
                continue;
            end

            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                r[d] = exp_rdy(d);
                model_step(d, r[d]);
                for (int i = 0; i < N; i++) begin
                    if (sv[d][i] && r[d][i]) begin
                        cur[d][i] = new_byte();
                        sv[d][i]  = 1'b0;
                    end
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/byte_stream_arbiter.md
Name: byte_stream_arbiter

Overview:
Shares one downstream byte sink (valid/ready byte stream, e.g. the UART TX path or a byte_sink instance) between NUM_SRC byte-stream requesters. It uses round-robin arbitration with burst/packet locking, so bytes from different sources are not interleaved mid-message. It has a single-entry registered output stage and sits between the per-client byte producers and the shared sink.

Parameters:
NUM_SRC, 4, number of requesting byte sources (2..8)
MAX_BURST, 8, maximum bytes transferred per grant before a forced release (1..255)
EOP_ENABLE, 1, 1 = hold grant until EOP byte or MAX_BURST; 0 = also release on a source bubble
EOP_BYTE, 8'h0A, end-of-packet byte value (transferred, then grant released)

Ports:
_clock  input  1  system clock, all state on rising edge
_reset  input  1  asynchronous, active-low reset (0 = in reset)
_in  input  NUM_SRC*8  source bytes, source i at bits [8i+7:8i]
_in_valid  input  NUM_SRC  per-source byte valid
_in_ready  output  NUM_SRC  per-source ready; at most one bit high per cycle
_out  output  8  registered byte to sink
_out_valid  output  1  _out holds an untransferred byte
_out_ready  input  1  sink ready
_out_src  output  $clog2(NUM_SRC)  source index of byte on _out
_busy  output  1  high while in GRANT state or _out_valid is high

Behaviour:
- Reset (_reset low, asynchronous):
  - state=IDLE; _out=0; _out_valid=0; _out_src=0; _in_ready=0; burst count=0.
  - last_grant=NUM_SRC-1, so source 0 wins the first arbitration.
  - Any byte held in the output register is discarded.
- Transfers:
  - Input transfer: _in_valid[i] && _in_ready[i].
  - Output transfer: _out_valid && _out_ready.
- States: IDLE, GRANT.
- IDLE:
  - _in_ready all 0.
  - If any _in_valid is high, select the first valid source scanning last_grant+1, last_grant+2, ... (mod NUM_SRC).
  - Register that source as grant, set last_grant=grant, clear the burst count, go to GRANT.
  - Arbitration costs exactly one cycle; no source is granted in the cycle its request is first seen.
- GRANT:
  - _in_ready[grant] = (!_out_valid || _out_ready); all other bits are 0.
  - This is a combinational path from _out_ready, giving full throughput.
  - On an input transfer: _out <= _in[grant], _out_src <= grant, _out_valid <= 1, burst count += 1.
  - Latency: a byte accepted in cycle N is on _out in cycle N+1.
  - If an output transfer occurs with no input transfer, _out_valid <= 0.
- Release from GRANT to IDLE (next cycle), evaluated in priority order on the cycle of the triggering event:
  - a) An input transfer makes burst count == MAX_BURST.
  - b) EOP_ENABLE=1 and the transferred byte == EOP_BYTE.
  - c) EOP_ENABLE=0 and _in_valid[grant]==0.
  - With EOP_ENABLE=1, source bubbles do not release the grant.
  - A granted source stalled by _out_ready=0 keeps the grant indefinitely; no timeout.
- The output register drains independently of state. IDLE may hold _out_valid=1 until the sink accepts.
- Burst count is 8 bits and saturates; it never wraps within a grant.
- Simultaneous output and input transfer in the same cycle: the register is overwritten with the new byte, and _out_valid stays 1.
- Round-robin fairness: with all sources continuously valid, grants go 0,1,2,3,0,...; each grant is at most MAX_BURST bytes.
- Changes to _in_valid on non-granted sources have no effect during GRANT.
- Reset asserted mid-GRANT: the grant is dropped immediately. After release, arbitration restarts from last_grant+1; a partial packet is not resumed.

Test Plan:
- Reset, then only src 2 valid with bytes 41,42,0A; sink always ready -> grant in cycle 2, _out shows 41,42,0A on consecutive cycles with _out_src=2, then IDLE; _in_ready never high for src 0/1/3.
- All 4 sources valid, each with 20 non-EOP bytes; sink always ready; MAX_BURST=8 -> output groups of 8 from src 0,1,2,3,0,...; one bubble cycle between groups; no interleaving within a group.
- Src 1 sends 55, bubbles 3 cycles, then 0A; src 3 valid throughout; EOP_ENABLE=1 -> src 3 is not granted until after 0A from src 1.
- Same stimulus with EOP_ENABLE=0 -> grant released on the first bubble, src 3 granted next.
- Src 0 streaming; _out_ready low for 5 cycles -> _out holds a stable byte, _in_ready[0]=0, no bytes lost or duplicated; sequence intact after release.
- _reset pulsed low mid-burst of src 1 -> _out_valid and _in_ready drop asynchronously; after reset, src 0 wins if valid.
